// File: rtl/rbfu_stream.sv
// rbfu_stream -- streaming reconfigurable butterfly unit for NTT-style lattice
// arithmetic.
//
// Each beat carries LANES coefficient triples (a, b, w) and an opcode:
//   00 NTT  : Cooley-Tukey butterfly    x = a + w*b,           y = a - w*b
//   01 INTT : Gentleman-Sande butterfly x = (a+b)/2,           y = ((b-a)/2)*w
//   10 PWM  : degree-1 pointwise multiply on lane pairs (2k, 2k+1)
//   11      : reserved, zero results with out_err raised
// All arithmetic is modulo Q. Operands are assumed to be already reduced.
//
// The pipeline has three register stages and a single global advance enable:
//   p0 : registered operands
//   p1 : first-level products and halvings
//   p2 : final modular add/sub/multiply (drives the outputs)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         input handshake
//   in_op, in_tag               opcode and opaque sideband tag
//   in_a, in_b, in_w            per-lane operands, lane k at [k*DW +: DW]
//   out_valid / out_ready       output handshake
//   out_op, out_tag             opcode and tag of the output beat
//   out_x, out_y                per-lane results
//   out_err                     output beat carried the reserved opcode
//   busy                        at least one beat is in flight
module rbfu_stream #(
    parameter int DW    = 12,
    parameter int Q     = 3329,
    parameter int LANES = 2,
    parameter int TW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [TW-1:0]       in_tag,
    input  logic [LANES*DW-1:0] in_a,
    input  logic [LANES*DW-1:0] in_b,
    input  logic [LANES*DW-1:0] in_w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_op,
    output logic [TW-1:0]       out_tag,
    output logic [LANES*DW-1:0] out_x,
    output logic [LANES*DW-1:0] out_y,
    output logic                out_err,
    output logic                busy
);

    localparam int LW = LANES * DW;

    localparam logic [1:0] OP_NTT  = 2'b00;
    localparam logic [1:0] OP_INTT = 2'b01;
    localparam logic [1:0] OP_PWM  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [DW:0]     QW1 = (DW+1)'(Q);
    localparam logic [2*DW-1:0] QW2 = (2*DW)'(Q);

    // Modular helpers. Inputs are assumed to lie in [0, Q-1].
    function automatic logic [DW-1:0] addmod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QW1) s = s - QW1;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] submod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + QW1 - {1'b0, y};
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        return DW'(p % QW2);
    endfunction

    // Division by 2 in the field: odd values get Q added first so the
    // shift is exact (Q is odd, so v+Q is even).
    function automatic logic [DW-1:0] half(input logic [DW-1:0] v);
        logic [DW:0] s;
        s = v[0] ? ({1'b0, v} + QW1) : {1'b0, v};
        return s[DW:1];
    endfunction

    function automatic logic [DW-1:0] lane(input logic [LW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    logic            en;
    logic            vld_p0, vld_p1, vld_p2;
    logic [1:0]      op_p0, op_p1, op_p2;
    logic [TW-1:0]   tag_p0, tag_p1, tag_p2;
    logic [LW-1:0]   a_p0, b_p0, w_p0;
    logic [LW-1:0]   u_p1, v_p1, w_p1;
    logic [LW-1:0]   x_p2, y_p2;
    logic            err_p2;
    logic [LW-1:0]   u_c, v_c, x_c, y_c;

    // A full output register that is not being taken stalls every stage.
    assign en       = !vld_p2 || out_ready;
    assign in_ready = en;

    // p0 -> p1: per-op first-level terms.
    //   NTT : u = a,          v = w*b
    //   INTT: u = half(a+b),  v = half(b-a)
    //   PWM : lane 2k   u = f0*g0, v = f1*g1 (tw rides along in w)
    //         lane 2k+1 u = (f0+f1)*(g0+g1)
    always_comb begin
        u_c = '0;
        v_c = '0;
        case (op_p0)
            OP_NTT: begin
                for (int k = 0; k < LANES; k++) begin
                    u_c[k*DW +: DW] = lane(a_p0, k);
                    v_c[k*DW +: DW] = mulmod(lane(w_p0, k), lane(b_p0, k));
                end
            end
            OP_INTT: begin
                for (int k = 0; k < LANES; k++) begin
                    u_c[k*DW +: DW] = half(addmod(lane(a_p0, k), lane(b_p0, k)));
                    v_c[k*DW +: DW] = half(submod(lane(b_p0, k), lane(a_p0, k)));
                end
            end
            OP_PWM: begin
                for (int k = 0; k < LANES; k += 2) begin
                    u_c[k*DW +: DW]     = mulmod(lane(a_p0, k), lane(b_p0, k));
                    v_c[k*DW +: DW]     = mulmod(lane(a_p0, k+1), lane(b_p0, k+1));
                    u_c[(k+1)*DW +: DW] = mulmod(addmod(lane(a_p0, k), lane(a_p0, k+1)),
                                                 addmod(lane(b_p0, k), lane(b_p0, k+1)));
                end
            end
            default: ;
        endcase
    end

    // p1 -> p2: final combination.
    //   PWM: x = f0g0 + f1g1*tw, y = (f0+f1)(g0+g1) - f0g0 - f1g1 (Karatsuba)
    always_comb begin
        x_c = '0;
        y_c = '0;
        case (op_p1)
            OP_NTT: begin
                for (int k = 0; k < LANES; k++) begin
                    x_c[k*DW +: DW] = addmod(lane(u_p1, k), lane(v_p1, k));
                    y_c[k*DW +: DW] = submod(lane(u_p1, k), lane(v_p1, k));
                end
            end
            OP_INTT: begin
                for (int k = 0; k < LANES; k++) begin
                    x_c[k*DW +: DW] = lane(u_p1, k);
                    y_c[k*DW +: DW] = mulmod(lane(v_p1, k), lane(w_p1, k));
                end
            end
            OP_PWM: begin
                for (int k = 0; k < LANES; k += 2) begin
                    x_c[k*DW +: DW] = addmod(lane(u_p1, k), mulmod(lane(v_p1, k), lane(w_p1, k)));
                    y_c[k*DW +: DW] = submod(submod(lane(u_p1, k+1), lane(u_p1, k)), lane(v_p1, k));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            op_p0  <= '0;
            op_p1  <= '0;
            op_p2  <= '0;
            tag_p0 <= '0;
            tag_p1 <= '0;
            tag_p2 <= '0;
            a_p0   <= '0;
            b_p0   <= '0;
            w_p0   <= '0;
            u_p1   <= '0;
            v_p1   <= '0;
            w_p1   <= '0;
            x_p2   <= '0;
            y_p2   <= '0;
            err_p2 <= 1'b0;
        end else if (en) begin
            // input -> p0
            vld_p0 <= in_valid;
            op_p0  <= in_op;
            tag_p0 <= in_tag;
            a_p0   <= in_a;
            b_p0   <= in_b;
            w_p0   <= in_w;
            // p0 -> p1
            vld_p1 <= vld_p0;
            op_p1  <= op_p0;
            tag_p1 <= tag_p0;
            u_p1   <= u_c;
            v_p1   <= v_c;
            w_p1   <= w_p0;
            // p1 -> p2
            vld_p2 <= vld_p1;
            op_p2  <= op_p1;
            tag_p2 <= tag_p1;
            x_p2   <= x_c;
            y_p2   <= y_c;
            err_p2 <= (op_p1 == OP_RSV);
        end
    end

    // Bubbles carry stale operands, so everything visible is gated by valid.
    assign out_valid = vld_p2;
    assign out_op    = vld_p2 ? op_p2  : 2'b00;
    assign out_tag   = vld_p2 ? tag_p2 : '0;
    assign out_x     = vld_p2 ? x_p2   : '0;
    assign out_y     = vld_p2 ? y_p2   : '0;
    assign out_err   = vld_p2 && err_p2;
    assign busy      = vld_p0 || vld_p1 || vld_p2;

endmodule

// File: tb/tb_rbfu_stream.sv
// Self-checking bench for rbfu_stream (Q=3329, LANES=2, DW=12, TW=4).
// A reference model computes each accepted beat's result into a scoreboard
// queue; the monitor pops and compares whenever an output beat transfers.
module tb_rbfu_stream;

    localparam int DW    = 12;
    localparam int Q     = 3329;
    localparam int LANES = 2;
    localparam int TW    = 4;
    localparam int LW    = LANES * DW;

    typedef struct packed {
        logic [1:0]    op;
        logic [TW-1:0] tag;
        logic [LW-1:0] x;
        logic [LW-1:0] y;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic [LW-1:0] in_a, in_b, in_w;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_op;
    logic [TW-1:0] out_tag;
    logic [LW-1:0] out_x, out_y;
    logic          out_err;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sbq[$];
    int   obs_tag[$];
    int   obs_cyc[$];
    exp_t mon_e;

    rbfu_stream #(.DW(DW), .Q(Q), .LANES(LANES), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag),
        .in_a(in_a), .in_b(in_b), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_tag(out_tag),
        .out_x(out_x), .out_y(out_y),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int md(input int v);
        return ((v % Q) + Q) % Q;
    endfunction

    function automatic int hf(input int v);
        return (v % 2 == 0) ? v / 2 : (v + Q) / 2;
    endfunction

    function automatic logic [LW-1:0] pk(input int l0, input int l1);
        return {DW'(l1), DW'(l0)};
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [TW-1:0] tag,
                                   input logic [LW-1:0] a, input logic [LW-1:0] b,
                                   input logic [LW-1:0] w);
        exp_t e;
        int av[LANES];
        int bv[LANES];
        int wv[LANES];
        int t;
        e.op  = op;
        e.tag = tag;
        e.x   = '0;
        e.y   = '0;
        e.err = (op == 2'b11);
        for (int k = 0; k < LANES; k++) begin
            av[k] = int'(a[k*DW +: DW]);
            bv[k] = int'(b[k*DW +: DW]);
            wv[k] = int'(w[k*DW +: DW]);
        end
        case (op)
            2'b00: for (int k = 0; k < LANES; k++) begin
                t = md(wv[k] * bv[k]);
                e.x[k*DW +: DW] = DW'(md(av[k] + t));
                e.y[k*DW +: DW] = DW'(md(av[k] - t));
            end
            2'b01: for (int k = 0; k < LANES; k++) begin
                e.x[k*DW +: DW] = DW'(hf(md(av[k] + bv[k])));
                e.y[k*DW +: DW] = DW'(md(hf(md(bv[k] - av[k])) * wv[k]));
            end
            2'b10: for (int k = 0; k < LANES; k += 2) begin
                e.x[k*DW +: DW] = DW'(md(av[k] * bv[k] + md(av[k+1] * bv[k+1]) * wv[k]));
                e.y[k*DW +: DW] = DW'(md((av[k] + av[k+1]) * (bv[k] + bv[k+1])
                                         - av[k] * bv[k] - av[k+1] * bv[k+1]));
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: signals are stable mid-cycle, so the negedge sees exactly
    // what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_op",  out_op,  mon_e.op);
                    check("sb_tag", out_tag, mon_e.tag);
                    check("sb_x",   out_x,   mon_e.x);
                    check("sb_y",   out_y,   mon_e.y);
                    check("sb_err", out_err, mon_e.err);
                    obs_tag.push_back(int'(out_tag));
                    obs_cyc.push_back(cyc);
                end
            end else if (!out_valid) begin
                check("idle_zero", {out_x, out_y, out_op, out_tag, out_err}, 0);
            end
            if (in_valid && in_ready)
                sbq.push_back(model(in_op, in_tag, in_a, in_b, in_w));
        end
    end

    // Presents one beat starting just after a rising edge and returns just
    // after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic [TW-1:0] tag,
                        input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic [LW-1:0] w);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = tag;
        in_a     = a;
        in_b     = b;
        in_w     = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_single(input string name, input logic [1:0] op,
                              input logic [LW-1:0] a, input logic [LW-1:0] b,
                              input logic [LW-1:0] w,
                              input int ex0, input int ey0, input int ex1, input int ey1);
        int lat;
        int cnt;
        lat = 0;
        cnt = 0;
        send(op, 4'd9, a, b, w);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (lat == 0) begin
                    lat = i;
                    check({name, "_x0"}, out_x[DW-1:0],    ex0);
                    check({name, "_y0"}, out_y[DW-1:0],    ey0);
                    check({name, "_x1"}, out_x[LW-1:DW],   ex1);
                    check({name, "_y1"}, out_y[LW-1:DW],   ey1);
                end
            end
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_valid_cycles"}, cnt, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sbq.size(), 0);
    endtask

    logic [1:0]    r_op[6];
    logic [LW-1:0] r_a[6], r_b[6], r_w[6];
    logic [LW-1:0] hold_x, hold_y;
    logic [TW-1:0] hold_tag;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_tag    = '0;
        in_a      = '0;
        in_b      = '0;
        in_w      = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy",      busy,      0);
            check("rst_out_err",   out_err,   0);
            check("rst_data",      {out_x, out_y}, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_busy",      busy,      0);
        check("post_rst_in_ready",  in_ready,  1);
        check("post_rst_data",      {out_x, out_y, out_tag, out_err}, 0);
        @(posedge clk);
        #1;

        // Directed single beats
        run_single("ntt",  2'b00, pk(1, 0), pk(2, 0), pk(3, 0), 7, 3324, 0, 0);
        run_single("intt", 2'b01, pk(5, 0), pk(3, 0), pk(1, 0), 4, 3328, 0, 0);
        run_single("pwm",  2'b10, pk(1, 2), pk(3, 4), pk(5, 0), 43, 10, 0, 0);
        run_single("rsv",  2'b11, pk(7, 8), pk(9, 10), pk(11, 12), 0, 0, 0, 0);
        // Boundary operands Q-1
        run_single("ntt_max", 2'b00, pk(Q-1, 0), pk(Q-1, Q-1), pk(Q-1, 1),
                   0, Q-2, Q-1, 1);
        drain();

        // Back-to-back mixed ops, tags 1..4
        obs_tag.delete();
        obs_cyc.delete();
        send(2'b00, 4'd1, pk(1, 100), pk(2, 200), pk(3, 300));
        send(2'b01, 4'd2, pk(5, 17),  pk(3, 3000), pk(1, 45));
        send(2'b10, 4'd3, pk(1, 2),   pk(3, 4),    pk(5, 0));
        send(2'b11, 4'd4, pk(6, 6),   pk(6, 6),    pk(6, 6));
        drain();
        check("b2b_count", obs_tag.size(), 4);
        for (int i = 0; i < obs_tag.size() && i < 4; i++) begin
            check("b2b_tag", obs_tag[i], i + 1);
            if (i > 0) check("b2b_gap", obs_cyc[i] - obs_cyc[i-1], 1);
        end

        // Stream of 6 with a 2-cycle output stall after the third beat
        for (int i = 0; i < 6; i++) begin
            r_op[i] = 2'($urandom_range(0, 3));
            r_a[i]  = pk($urandom_range(0, Q-1), $urandom_range(0, Q-1));
            r_b[i]  = pk($urandom_range(0, Q-1), $urandom_range(0, Q-1));
            r_w[i]  = pk($urandom_range(0, Q-1), $urandom_range(0, Q-1));
        end
        obs_tag.delete();
        obs_cyc.delete();
        for (int i = 0; i < 3; i++) send(r_op[i], TW'(5 + i), r_a[i], r_b[i], r_w[i]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = r_op[3];
        in_tag    = TW'(8);
        in_a      = r_a[3];
        in_b      = r_b[3];
        in_w      = r_w[3];
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("stall_in_ready",  in_ready,  0);
            check("stall_out_valid", out_valid, 1);
            if (j == 0) begin
                hold_x   = out_x;
                hold_y   = out_y;
                hold_tag = out_tag;
                check("stall_first_tag", out_tag, 5);
            end else begin
                check("stall_hold_x",   out_x,   hold_x);
                check("stall_hold_y",   out_y,   hold_y);
                check("stall_hold_tag", out_tag, hold_tag);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) send(r_op[i], TW'(5 + i), r_a[i], r_b[i], r_w[i]);
        drain();
        check("stream_count", obs_tag.size(), 6);
        for (int i = 0; i < obs_tag.size() && i < 6; i++)
            check("stream_tag", obs_tag[i], 5 + i);

        // Reset with three beats in flight and a simultaneous input beat
        obs_tag.delete();
        obs_cyc.delete();
        for (int i = 0; i < 3; i++) send(2'b00, TW'(1 + i), pk(i, 1), pk(2, i), pk(3, 3));
        check("flush_busy_before", busy, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_tag   = 4'd15;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_busy",      busy,      0);
        check("flush_in_ready",  in_ready,  1);
        check("flush_data",      {out_x, out_y, out_err}, 0);
        @(posedge clk);
        #1;
        run_single("post_flush", 2'b00, pk(1, 0), pk(2, 0), pk(3, 0), 7, 3324, 0, 0);
        drain();
        check("flush_obs_count", obs_tag.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
